// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory:
// single-outstanding request, ack returns the word in the same cycle.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [31:0]     rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, small prefetch FIFO,
// one instruction per cycle into decode, flush/restart on execute redirect.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    fetch_unit_if.master    imem,
    input  logic            stall_D,
    input  logic            stall_M,
    input  logic            redirect_E,
    input  logic [XLEN-1:0] target_E,
    output logic [29:0]     instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic            valid_D
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [29:0]      NOP     = 30'h4;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [29:0]     instr;
    } entry_t;

    state_t           state;
    state_t           state_next;
    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  fpc_next;
    logic [XLEN-1:0]  addr_q;
    entry_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             advance;
    logic             push;
    logic             pop;
    logic             has_room;
    logic             unused_rdata_lsbs;

    // Compressed instructions are not supported, so the low bits never matter.
    assign unused_rdata_lsbs = ^imem.rdata[1:0];

    assign advance  = !(stall_D || stall_M);
    assign push     = (state == REQ) && imem.ack && !redirect_E;
    assign pop      = !redirect_E && advance && (count != '0);
    assign has_room = (count < DEPTH_C);

    always_comb begin
        // NOTE: assign a default first so every path drives the signal; a path
        // that leaves it unassigned infers a latch.
        count_next = count;
        if (redirect_E)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

    always_comb begin
        fpc_next = fpc;
        if (redirect_E)
            fpc_next = target_E & ~XLEN'(3);
        else if (push)
            fpc_next = fpc + XLEN'(4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of the order in which the blocks are evaluated.
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (!redirect_E && has_room) state_next = REQ;
            REQ: begin
                if (imem.ack)
                    state_next = (redirect_E || (count_next < DEPTH_C)) ? REQ : IDLE;
                else if (redirect_E)
                    state_next = DROP;
            end
            DROP: if (imem.ack) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem.req = (state != IDLE);
    end

    // The bus address only moves when no request is in flight, so a redirect
    // during DROP updates fpc without disturbing the pending address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fpc    <= RESET_VECTOR;
            addr_q <= RESET_VECTOR;
        end else begin
            fpc <= fpc_next;
            if ((state == IDLE) || imem.ack)
                addr_q <= fpc_next;
        end
    end

    assign imem.addr = addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (redirect_E) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{pc: fpc, instr: imem.rdata[31:2]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_D <= NOP;
            pc_D    <= '0;
            valid_D <= 1'b0;
        end else if (redirect_E) begin
            instr_D <= NOP;
            valid_D <= 1'b0;
        end else if (advance) begin
            if (count != '0) begin
                instr_D <= fifo_mem[rd_ptr].instr;
                pc_D    <= fifo_mem[rd_ptr].pc;
                valid_D <= 1'b1;
            end else begin
                instr_D <= NOP;
                valid_D <= 1'b0;
            end
        end
    end
endmodule
